// File: rtl/tx_buffer_control.sv
// Drains the TX buffer FIFO into the RS-232 transmitter one byte at a time,
// pacing bytes into bursts with idle gaps and flagging a stalled transmitter.
module tx_buffer_control #(
    parameter int BURST_MAX   = 64,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        genclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        tx_empty,
    input  logic [7:0]  tx_data,
    input  logic        tbre,
    input  logic        clr_err,
    output logic        tx_rd,
    output logic [7:0]  tbr,
    output logic        wrn,
    output logic        busy,
    output logic        err,
    output logic [15:0] sent_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_LOAD,
        S_WAIT_ACC,
        S_WAIT_RDY,
        S_GAP
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        tx_rd_q, tx_rd_d;
    logic        wrn_q, wrn_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [7:0]  tbr_q, tbr_d;
    logic [15:0] sent_q, sent_d;
    logic [7:0]  burst_q, burst_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        fresh_q, fresh_d;
    logic        timeout;

    always_comb begin
        state_d = state_q;
        tbr_d   = tbr_q;
        sent_d  = sent_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        timeout = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !tx_empty) state_d = S_POP;
            end
            S_POP: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // tx_data is only valid on the first LATCH cycle after the pop
                if (fresh_q) tbr_d = tx_data;
                if (tbre) state_d = S_LOAD;
            end
            S_LOAD: begin
                tmo_d   = '0;
                state_d = S_WAIT_ACC;
            end
            S_WAIT_ACC: begin
                if (!tbre) begin
                    sent_d  = sent_q + 16'd1;
                    burst_d = burst_q + 8'd1;
                    state_d = S_WAIT_RDY;
                end else if (tmo_q == TMO_LAST) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WAIT_RDY: begin
                if (tbre) begin
                    if (burst_q == BURST_LIM) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else if (enable && !tx_empty) begin
                        state_d = S_POP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + 8'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_IDLE) burst_d = '0;

        // Strobes are registered from the next state so they line up with it
        tx_rd_d = (state_d == S_POP);
        wrn_d   = (state_d != S_LOAD);
        busy_d  = (state_d != S_IDLE);
        fresh_d = (state_q == S_POP);
        err_d   = timeout | (err_q & ~clr_err);
    end

    always_ff @(posedge genclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tx_rd_q <= 1'b0;
            wrn_q   <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            tbr_q   <= '0;
            sent_q  <= '0;
            burst_q <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_rd_q <= tx_rd_d;
            wrn_q   <= wrn_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            tbr_q   <= tbr_d;
            sent_q  <= sent_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            fresh_q <= fresh_d;
        end
    end

    assign tx_rd      = tx_rd_q;
    assign wrn        = wrn_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign tbr        = tbr_q;
    assign sent_count = sent_q;

endmodule
